i2s_tx: RTL

- Dedicated I2S transmitter between the core's 16-bit stereo audio output and the on-board I2S DAC pins.
- Replaces the integer-divided bit clock with a fractional phase accumulator, so the average sample rate is exact.
- Latches one stereo sample per frame and emits standard Philips I2S: 32 bclk per frame, 16 bits per channel, MSB first, data delayed one bclk after the lrck edge.
- Pulses a per-frame strobe for upstream sample pacing.

---
 rtl/i2s_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
// Philips-format I2S transmitter for a 16-bit stereo stream.
//
// The bit clock is produced by a fractional phase accumulator instead of an
// integer divider, so the long-run sample rate is exactly SAMPLE_HZ even when
// CLK_HZ is not a multiple of 64*SAMPLE_HZ. Each frame is 32 bclk periods:
// 16 bits left then 16 bits right, MSB first, data delayed by one bclk after
// the lrck edge.
//
// Ports:
//   clk32         in   system clock (CLK_HZ)
//   reset_n       in   asynchronous active-low reset
//   enable        in   run when high; when low, state clears on the next edge
//   audio_l       in   16-bit signed left sample
//   audio_r       in   16-bit signed right sample
//   sample_strobe out  high for the single clk32 cycle whose closing edge
//                      captures audio_l/audio_r
//   i2s_bclk      out  bit clock, 32*SAMPLE_HZ on average
//   i2s_lrck      out  word select, 0 = left, 1 = right
//   i2s_din       out  serial data, changes only when bclk falls
// ---------------------------------------------------------------------------
module i2s_tx #(
    parameter int CLK_HZ    = 32000000,
    parameter int SAMPLE_HZ = 48000,
    parameter int ACC_W     = 27
) (
    input  logic        clk32,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] audio_l,
    input  logic [15:0] audio_r,
    output logic        sample_strobe,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_din
);

    // Two bclk toggles per bit, 32 bits per frame.
    localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(64 * SAMPLE_HZ);
    localparam logic [ACC_W-1:0] ACC_LIM = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [ACC_W-1:0] acc_sum;
    logic             bclk_q,  bclk_d;
    logic             lrck_q,  lrck_d;
    logic             din_q,   din_d;
    logic [4:0]       slot_q,  slot_d;
    logic [31:0]      shift_q, shift_d;
    logic             toggle;
    logic             fall;

    // acc_q stays below CLK_HZ, so acc_sum fits in ACC_W bits by construction.
    assign acc_sum = acc_q + ACC_INC;
    assign toggle  = enable && (acc_sum >= ACC_LIM);
    assign fall    = toggle && bclk_q;

    // The strobe marks the cycle whose closing edge loads the new sample, so
    // upstream may still present a fresh value during the strobe cycle.
    assign sample_strobe = fall && (slot_q == 5'd0);

    always_comb begin
        acc_d   = acc_q;
        bclk_d  = bclk_q;
        lrck_d  = lrck_q;
        din_d   = din_q;
        slot_d  = slot_q;
        shift_d = shift_q;

        if (!enable) begin
            acc_d   = '0;
            bclk_d  = 1'b0;
            lrck_d  = 1'b0;
            din_d   = 1'b0;
            slot_d  = 5'd0;
            shift_d = '0;
        end else if (toggle) begin
            acc_d  = acc_sum - ACC_LIM;
            bclk_d = ~bclk_q;
            if (bclk_q) begin
                lrck_d = slot_q[4];
                slot_d = slot_q + 5'd1;
                // After 31 shifts the previous frame's R[0] sits in bit 31,
                // so slot 0 emits it while the new sample is loaded.
                din_d  = shift_q[31];
                if (slot_q == 5'd0) begin
                    shift_d = {audio_l, audio_r};
                end else begin
                    shift_d = {shift_q[30:0], 1'b0};
                end
            end
        end else begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            din_q   <= 1'b0;
            slot_q  <= 5'd0;
            shift_q <= '0;
        end else begin
            acc_q   <= acc_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            din_q   <= din_d;
            slot_q  <= slot_d;
            shift_q <= shift_d;
        end
    end

    assign i2s_bclk = bclk_q;
    assign i2s_lrck = lrck_q;
    assign i2s_din  = din_q;

endmodule
